// File: rtl/syncn_pgen.sv
// syncn_pgen: multi-channel CDC synchroniser producing a level, an edge pulse and sticky pend/ovf flags.
// Optional glitch filter on the synchronised level is compiled in with `define SYNCN_PGEN_FILT_EN.
module syncn_pgen #(
    parameter int WIDTH     = 1,
    parameter int STAGES    = 2,
    parameter int MODE      = 2,
    parameter bit RESET_VAL = 1'b0,
    parameter int FILT_LEN  = 4
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] pend,
    output logic [WIDTH-1:0] ovf
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("syncn_pgen: STAGES must be in 2..4");
    end
    if (FILT_LEN < 2 || FILT_LEN > 16) begin : g_bad_filt
        $error("syncn_pgen: FILT_LEN must be in 2..16");
    end

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_hist;
    logic [WIDTH-1:0] w_pulse;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_ovf;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= {WIDTH{RESET_VAL}};
            end
        end else begin
            r_sync[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

`ifdef SYNCN_PGEN_FILT_EN
    localparam int CNT_W = $clog2(FILT_LEN);

    logic [WIDTH-1:0] r_filt;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // A new level is accepted only after it has persisted FILT_LEN cycles past the synchroniser.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= {WIDTH{RESET_VAL}};
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync[STAGES-1][i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync[STAGES-1][i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync[STAGES-1];
`endif

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= {WIDTH{RESET_VAL}};
        end else begin
            r_hist <= w_filt;
        end
    end

    if (MODE == 0) begin : g_rise
        assign w_pulse = w_filt & ~r_hist;
    end else if (MODE == 1) begin : g_fall
        assign w_pulse = ~w_filt & r_hist;
    end else if (MODE == 2) begin : g_both
        assign w_pulse = w_filt ^ r_hist;
    end else begin : g_bad_mode
        $error("syncn_pgen: MODE must be 0, 1 or 2");
        assign w_pulse = '0;
    end

    // A new event outranks a same-cycle clear, so an event is never dropped silently.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= w_pulse | (r_pend & ~clr);
            r_ovf  <= (w_pulse & r_pend & ~clr) | (r_ovf & ~clr);
        end
    end

    assign q    = r_hist;
    assign p    = w_pulse;
    assign pend = r_pend;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_syncn_pgen.sv
// Scoreboard bench for syncn_pgen: four instances cover the rising, toggle, falling/reset-high and pend/ovf cases.
`timescale 1ns/1ps
module tb_syncn_pgen;

`ifdef SYNCN_PGEN_FILT_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif
    localparam int LA = 3 + FL;
    localparam int LB = 2 + FL;
    localparam int LC = 2 + FL;
    localparam int LD = 2 + FL;

    localparam int PA = 0, QA = 1, PNA = 2, OVA = 3;
    localparam int PB = 4, QB = 5, PC = 6, QC = 7;
    localparam int PD = 8, QD = 9, PND = 10, OVD = 11;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] exp;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq[$];

    logic       rst_a, rst_b, rst_c, rst_d;
    logic [3:0] d_a, clr_a, q_a, p_a, pend_a, ovf_a;
    logic       d_b, clr_b, q_b, p_b, pend_b, ovf_b;
    logic       d_c, clr_c, q_c, p_c, pend_c, ovf_c;
    logic       d_d, clr_d, q_d, p_d, pend_d, ovf_d;

    syncn_pgen #(.WIDTH(4), .STAGES(3), .MODE(0), .RESET_VAL(1'b0), .FILT_LEN(4)) u_a (
        .c(clk), .rst_n(rst_a), .d(d_a), .clr(clr_a), .q(q_a), .p(p_a), .pend(pend_a), .ovf(ovf_a));
    syncn_pgen #(.WIDTH(1), .STAGES(2), .MODE(2), .RESET_VAL(1'b0), .FILT_LEN(4)) u_b (
        .c(clk), .rst_n(rst_b), .d(d_b), .clr(clr_b), .q(q_b), .p(p_b), .pend(pend_b), .ovf(ovf_b));
    syncn_pgen #(.WIDTH(1), .STAGES(2), .MODE(1), .RESET_VAL(1'b1), .FILT_LEN(4)) u_c (
        .c(clk), .rst_n(rst_c), .d(d_c), .clr(clr_c), .q(q_c), .p(p_c), .pend(pend_c), .ovf(ovf_c));
    syncn_pgen #(.WIDTH(1), .STAGES(2), .MODE(0), .RESET_VAL(1'b0), .FILT_LEN(4)) u_d (
        .c(clk), .rst_n(rst_d), .d(d_d), .clr(clr_d), .q(q_d), .p(p_d), .pend(pend_d), .ovf(ovf_d));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs(input int s);
        case (s)
            PA:  return p_a;
            QA:  return q_a;
            PNA: return pend_a;
            OVA: return ovf_a;
            PB:  return {3'b000, p_b};
            QB:  return {3'b000, q_b};
            PC:  return {3'b000, p_c};
            QC:  return {3'b000, q_c};
            PD:  return {3'b000, p_d};
            QD:  return {3'b000, q_d};
            PND: return {3'b000, pend_d};
            OVD: return {3'b000, ovf_d};
            default: return 4'hx;
        endcase
    endfunction

    task automatic expect_at(input int c, input int sig, input logic [3:0] e, input string tag);
        exp_t t;
        t.cyc = c;
        t.sig = sig;
        t.exp = e;
        t.tag = tag;
        sbq.push_back(t);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                chk(sbq[i].tag, {28'd0, obs(sbq[i].sig)}, {28'd0, sbq[i].exp});
                sbq.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        d_a = 4'h0; d_b = 1'b0; d_c = 1'b1; d_d = 1'b0;
        clr_a = 4'h0; clr_b = 1'b0; clr_c = 1'b0; clr_d = 1'b0;
        @(negedge clk);

        // Reset state, then first cycles after release
        expect_at(2, PA, 4'h0, "rst_p_a");   expect_at(2, QA, 4'h0, "rst_q_a");
        expect_at(2, PNA, 4'h0, "rst_pend_a"); expect_at(2, OVA, 4'h0, "rst_ovf_a");
        expect_at(2, PB, 4'h0, "rst_p_b");   expect_at(2, QB, 4'h0, "rst_q_b");
        expect_at(2, PC, 4'h0, "rst_p_c");   expect_at(2, QC, 4'h1, "rst_q_c");
        expect_at(2, PND, 4'h0, "rst_pend_d"); expect_at(2, OVD, 4'h0, "rst_ovf_d");
        at(3);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        expect_at(4, PA, 4'h0, "post_rst_p_a");
        expect_at(4, QA, 4'h0, "post_rst_q_a");
        for (int k = 4; k <= 6 + LC; k++) begin
            expect_at(k, PC, 4'h0, "c_hold_p");
            expect_at(k, QC, 4'h1, "c_hold_q");
        end
        at(7 + LC);

        // Rising edge on channel 2 of the 4-wide, 3-stage instance
        b = cyc;
        d_a = 4'b0100;
        expect_at(b + LA - 1, PA, 4'h0, "a_p_early");
        expect_at(b + LA, PA, 4'b0100, "a_p_pulse");
        expect_at(b + LA + 1, PA, 4'h0, "a_p_after");
        expect_at(b + LA, QA, 4'h0, "a_q_before");
        expect_at(b + LA + 1, QA, 4'b0100, "a_q_set");
        expect_at(b + LA, PNA, 4'h0, "a_pend_before");
        expect_at(b + LA + 1, PNA, 4'b0100, "a_pend_set");
        expect_at(b + LA + 1, OVA, 4'h0, "a_ovf_clear");
        at(b + LA + 3);

        // Falling edge on the reset-high, MODE 1 instance
        b = cyc;
        d_c = 1'b0;
        expect_at(b + LC - 1, PC, 4'h0, "c_p_early");
        expect_at(b + LC, PC, 4'h1, "c_p_pulse");
        expect_at(b + LC + 1, PC, 4'h0, "c_p_after");
        expect_at(b + LC, QC, 4'h1, "c_q_before");
        expect_at(b + LC + 1, QC, 4'h0, "c_q_fall");
        at(b + LC + 3);

        // Toggle mode: both edges pulse, six cycles apart
        b = cyc;
        d_b = 1'b1;
        expect_at(b + LB - 1, PB, 4'h0, "b_p_early");
        expect_at(b + LB, PB, 4'h1, "b_p_rise");
        expect_at(b + LB + 1, PB, 4'h0, "b_p_rise_end");
        expect_at(b + LB + 1, QB, 4'h1, "b_q_high");
        expect_at(b + 6 + LB - 1, PB, 4'h0, "b_p_gap");
        expect_at(b + 6 + LB, PB, 4'h1, "b_p_fall");
        expect_at(b + 6 + LB + 1, PB, 4'h0, "b_p_fall_end");
        expect_at(b + 6 + LB, QB, 4'h1, "b_q_still_high");
        expect_at(b + 6 + LB + 1, QB, 4'h0, "b_q_low");
        at(b + 6);
        d_b = 1'b0;
        at(b + 6 + LB + 3);

        // Reset asserted mid-flight on the toggle instance
        b = cyc;
        d_b = 1'b1;
        at(b + 1);
        rst_b = 1'b0;
        expect_at(b + 2, PB, 4'h0, "b_rst_p");
        expect_at(b + 2, QB, 4'h0, "b_rst_q");
        expect_at(b + 3, PB, 4'h0, "b_rst_p2");
        at(b + 3);
        rst_b = 1'b1;
        expect_at(b + 3 + LB - 1, PB, 4'h0, "b_rel_p_early");
        expect_at(b + 3 + LB, PB, 4'h1, "b_rel_p_pulse");
        expect_at(b + 3 + LB + 1, PB, 4'h0, "b_rel_p_after");
        expect_at(b + 3 + LB + 1, QB, 4'h1, "b_rel_q");
        at(b + 3 + LB + 3);

        // Pending / overflow / clear handshake
        b = cyc;
        d_d = 1'b1;
        expect_at(b + LD, PD, 4'h1, "d_p_first");
        expect_at(b + LD, PND, 4'h0, "d_pend_before");
        expect_at(b + LD + 1, PND, 4'h1, "d_pend_set");
        expect_at(b + LD + 1, OVD, 4'h0, "d_ovf_none");
        at(b + 8);
        d_d = 1'b0;
        at(b + 16);
        d_d = 1'b1;
        expect_at(b + 16 + LD, PD, 4'h1, "d_p_second");
        expect_at(b + 16 + LD, OVD, 4'h0, "d_ovf_before");
        expect_at(b + 17 + LD, OVD, 4'h1, "d_ovf_set");
        expect_at(b + 17 + LD, PND, 4'h1, "d_pend_kept");
        at(b + 24);
        clr_d = 1'b1;
        expect_at(b + 25, PND, 4'h0, "d_clr_pend");
        expect_at(b + 25, OVD, 4'h0, "d_clr_ovf");
        at(b + 25);
        clr_d = 1'b0;
        expect_at(b + 26, PND, 4'h0, "d_pend_stays_clear");
        at(b + 26);
        d_d = 1'b0;
        at(b + 34);
        d_d = 1'b1;
        expect_at(b + 35 + LD, PND, 4'h1, "d_pend_reset");
        at(b + 42);
        d_d = 1'b0;
        at(b + 50);
        d_d = 1'b1;
        expect_at(b + 50 + LD, PD, 4'h1, "d_p_coinc");
        at(b + 50 + LD);
        clr_d = 1'b1;
        expect_at(b + 51 + LD, PND, 4'h1, "d_coinc_pend");
        expect_at(b + 51 + LD, OVD, 4'h0, "d_coinc_ovf");
        at(b + 51 + LD);
        clr_d = 1'b0;
        expect_at(b + 52 + LD, PND, 4'h1, "d_coinc_pend_hold");
        expect_at(b + 52 + LD, OVD, 4'h0, "d_coinc_ovf_hold");
        at(b + 53 + LD);
        d_d = 1'b0;
        at(cyc + 12);

`ifdef SYNCN_PGEN_FILT_EN
        // Glitch shorter than the filter is rejected; a long-enough level is accepted
        b = cyc;
        d_d = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            expect_at(b + k, PD, 4'h0, "f_glitch_p");
            expect_at(b + k, QD, 4'h0, "f_glitch_q");
        end
        at(b + 3);
        d_d = 1'b0;
        at(b + 12);
        b = cyc;
        d_d = 1'b1;
        expect_at(b + 5, PD, 4'h0, "f_p_early");
        expect_at(b + 6, PD, 4'h1, "f_p_pulse");
        expect_at(b + 7, PD, 4'h0, "f_p_after");
        expect_at(b + 7, QD, 4'h1, "f_q_high");
        at(b + 4);
        d_d = 1'b0;
        at(b + 9);
`endif

        at(cyc + 3);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
